// File: rtl/cpu_flag_monitor.sv
// cpu_flag_monitor: observes the MIPSCPU zero/carry/stack_overflow flags,
// counts their rising edges with saturating counters, latches the first
// stack overflow and requests a halt. One-cycle-latency register read port.
//
// Optional build macro: FLAG_MONITOR_CYCLE_CNT_EN
//   adds a saturating cycle counter (addr 4) and an overflow timestamp (addr 5).
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | counting edges, waiting for a stack_overflow rising edge
// TRIP  | one cycle after the overflow edge, counters still active
// HALT  | halt_req high, counters frozen, left only by clr or rst

module cpu_flag_monitor #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             zero,
   input  logic             carry,
   input  logic             stack_overflow,
   input  logic             clr,
   input  logic             rd_en,
   input  logic [2:0]       rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             halt_req,
   output logic             ovf_sticky
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TRIP = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             p_zero_q, p_zero_d;
   logic             p_carry_q, p_carry_d;
   logic             p_ovf_q, p_ovf_d;
   logic [CNT_W-1:0] cnt_zero_q, cnt_zero_d;
   logic [CNT_W-1:0] cnt_carry_q, cnt_carry_d;
   logic [CNT_W-1:0] cnt_ovf_q, cnt_ovf_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic             halt_req_q, halt_req_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0] rd_mux;
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ts_q, ts_d;
`endif

   logic edge_zero, edge_carry, edge_ovf, count_en;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign edge_zero  = zero & ~p_zero_q;
   assign edge_carry = carry & ~p_carry_q;
   assign edge_ovf   = stack_overflow & ~p_ovf_q;
   assign count_en   = (state_q != ST_HALT);

   // Next-state, counter and sticky logic; clr overrides any coincident edge.
   always_comb begin
      state_d      = state_q;
      cnt_zero_d   = cnt_zero_q;
      cnt_carry_d  = cnt_carry_q;
      cnt_ovf_d    = cnt_ovf_q;
      ovf_sticky_d = ovf_sticky_q;
      // Previous samples always follow the inputs, also on clr and in HALT,
      // so a flag held high across clr is not recounted.
      p_zero_d     = zero;
      p_carry_d    = carry;
      p_ovf_d      = stack_overflow;
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
      cyc_d        = cyc_q;
      ts_d         = ts_q;
`endif
      if (clr) begin
         state_d      = ST_RUN;
         cnt_zero_d   = '0;
         cnt_carry_d  = '0;
         cnt_ovf_d    = '0;
         ovf_sticky_d = 1'b0;
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
         cyc_d        = '0;
         ts_d         = '0;
`endif
      end else begin
         if (count_en) begin
            if (edge_zero)  cnt_zero_d  = sat_inc(cnt_zero_q);
            if (edge_carry) cnt_carry_d = sat_inc(cnt_carry_q);
            if (edge_ovf)   cnt_ovf_d   = sat_inc(cnt_ovf_q);
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
            cyc_d = sat_inc(cyc_q);
`endif
         end
         case (state_q)
            ST_RUN: begin
               if (edge_ovf) begin
                  ovf_sticky_d = 1'b1;
                  state_d      = ST_TRIP;
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
                  // Timestamp is the cycle count including the overflow cycle.
                  ts_d = sat_inc(cyc_q);
`endif
               end
            end
            ST_TRIP: state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
         endcase
      end
      halt_req_d = (state_d == ST_HALT);
   end

   // Read mux over pre-update register values.
   always_comb begin
      rd_mux = '0;
      case (rd_addr)
         3'd0: rd_mux = cnt_zero_q;
         3'd1: rd_mux = cnt_carry_q;
         3'd2: rd_mux = cnt_ovf_q;
         3'd3: rd_mux = {{(CNT_W-6){1'b0}}, state_q, ovf_sticky_q,
                         p_ovf_q, p_carry_q, p_zero_q};
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
         3'd4: rd_mux = cyc_q;
         3'd5: rd_mux = ts_q;
`endif
         default: rd_mux = '0;
      endcase
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? rd_mux : '0;
   end

   // State register; rst wins over clr and rd_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         p_zero_q     <= 1'b0;
         p_carry_q    <= 1'b0;
         p_ovf_q      <= 1'b0;
         cnt_zero_q   <= '0;
         cnt_carry_q  <= '0;
         cnt_ovf_q    <= '0;
         ovf_sticky_q <= 1'b0;
         halt_req_q   <= 1'b0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
         cyc_q        <= '0;
         ts_q         <= '0;
`endif
      end else begin
         state_q      <= state_d;
         p_zero_q     <= p_zero_d;
         p_carry_q    <= p_carry_d;
         p_ovf_q      <= p_ovf_d;
         cnt_zero_q   <= cnt_zero_d;
         cnt_carry_q  <= cnt_carry_d;
         cnt_ovf_q    <= cnt_ovf_d;
         ovf_sticky_q <= ovf_sticky_d;
         halt_req_q   <= halt_req_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
         cyc_q        <= cyc_d;
         ts_q         <= ts_d;
`endif
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign halt_req   = halt_req_q;
   assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_cpu_flag_monitor.sv
// Directed bench for cpu_flag_monitor: a CNT_W=16 and a CNT_W=8 instance
// share the same stimulus so saturation can be seen on the narrow one.

module tb_cpu_flag_monitor;

   logic        clk = 1'b0;
   logic        rst, zero, carry, stack_overflow, clr, rd_en;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data16;
   logic [7:0]  rd_data8;
   logic        rd_valid16, halt16, sticky16;
   logic        rd_valid8, halt8, sticky8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cpu_flag_monitor #(.CNT_W(16)) dut16 (
      .clk(clk), .rst(rst), .zero(zero), .carry(carry),
      .stack_overflow(stack_overflow), .clr(clr), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data16), .rd_valid(rd_valid16),
      .halt_req(halt16), .ovf_sticky(sticky16)
   );

   cpu_flag_monitor #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .zero(zero), .carry(carry),
      .stack_overflow(stack_overflow), .clr(clr), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data8), .rd_valid(rd_valid8),
      .halt_req(halt8), .ovf_sticky(sticky8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit so outputs are sampled off-edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_out(input string tag, input logic h, input logic s);
      check({tag, ".halt16"},   {31'd0, halt16},   {31'd0, h});
      check({tag, ".sticky16"}, {31'd0, sticky16}, {31'd0, s});
      check({tag, ".halt8"},    {31'd0, halt8},    {31'd0, h});
      check({tag, ".sticky8"},  {31'd0, sticky8},  {31'd0, s});
   endtask

   // Single read: response one cycle after rd_en, then rd_valid must drop.
   task automatic rd(input string tag, input logic [2:0] a,
                     input logic [15:0] e16, input logic [7:0] e8);
      rd_en = 1'b1;
      rd_addr = a;
      step();
      check({tag, ".valid16"}, {31'd0, rd_valid16}, 32'd1);
      check({tag, ".data16"},  {16'd0, rd_data16},  {16'd0, e16});
      check({tag, ".valid8"},  {31'd0, rd_valid8},  32'd1);
      check({tag, ".data8"},   {24'd0, rd_data8},   {24'd0, e8});
      rd_en = 1'b0;
      step();
      check({tag, ".valid16_drop"}, {31'd0, rd_valid16}, 32'd0);
      check({tag, ".valid8_drop"},  {31'd0, rd_valid8},  32'd0);
   endtask

   initial begin
      rst = 1'b1; zero = 1'b0; carry = 1'b0; stack_overflow = 1'b0;
      clr = 1'b0; rd_en = 1'b0; rd_addr = 3'd0;
      step(2);
      check("reset.rd_data16", {16'd0, rd_data16}, 32'd0);
      check("reset.rd_valid16", {31'd0, rd_valid16}, 32'd0);
      check("reset.rd_data8", {24'd0, rd_data8}, 32'd0);
      check_out("reset", 1'b0, 1'b0);
      rst = 1'b0;

      // zero held high for 5 cycles counts once
      zero = 1'b1;
      step(5);
      zero = 1'b0;
      step();
      rd("zero_hold", 3'd0, 16'd1, 8'd1);
      rd("ovf_none", 3'd2, 16'd0, 8'd0);

      // 10 carry edges
      for (int i = 0; i < 10; i++) begin
         carry = 1'b1; step();
         carry = 1'b0; step();
      end
      rd("carry10", 3'd1, 16'd10, 8'd10);

      // 290 more edges: 300 on the wide counter, saturated on the narrow one
      for (int i = 0; i < 290; i++) begin
         carry = 1'b1; step();
         carry = 1'b0; step();
      end
      rd("carry300", 3'd1, 16'd300, 8'd255);
      rd("status_run", 3'd3, 16'h00, 8'h00);

      // overflow edge: sticky now, halt one cycle later
      stack_overflow = 1'b1;
      step();
      check_out("ovf_edge", 1'b0, 1'b1);
      stack_overflow = 1'b0;
      rd_en = 1'b1; rd_addr = 3'd3;
      step();
      // pre-update status: TRIP, sticky, p_ovf=1
      check("trip_status16", {16'd0, rd_data16}, 32'h1C);
      check("trip_status8", {24'd0, rd_data8}, 32'h1C);
      check_out("halt_entry", 1'b1, 1'b1);
      rd_en = 1'b0;
      step();
      rd("status_halt", 3'd3, 16'h28, 8'h28);
      rd("ovf_count", 3'd2, 16'd1, 8'd1);

      // edges in HALT are not counted
      for (int i = 0; i < 3; i++) begin
         zero = 1'b1; carry = 1'b1; step();
         zero = 1'b0; carry = 1'b0; step();
      end
      rd("zero_frozen", 3'd0, 16'd1, 8'd1);
      rd("carry_frozen", 3'd1, 16'd300, 8'd255);
      check_out("still_halt", 1'b1, 1'b1);

      // clr in HALT with zero held high
      zero = 1'b1;
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      check_out("after_clr", 1'b0, 1'b0);
      rd("clr_status", 3'd3, 16'h01, 8'h01);
      rd("clr_zero", 3'd0, 16'd0, 8'd0);
      rd("clr_carry", 3'd1, 16'd0, 8'd0);
      rd("clr_ovf", 3'd2, 16'd0, 8'd0);
      step(3);
      rd("zero_held", 3'd0, 16'd0, 8'd0);
      zero = 1'b0; step();
      zero = 1'b1; step();
      rd("zero_genuine", 3'd0, 16'd1, 8'd1);

      // clr coinciding with a carry edge and a read
      for (int i = 0; i < 3; i++) begin
         carry = 1'b1; step();
         carry = 1'b0; step();
      end
      carry = 1'b1; clr = 1'b1; rd_en = 1'b1; rd_addr = 3'd1;
      step();
      check("clr_read_pre16", {16'd0, rd_data16}, 32'd3);
      check("clr_read_pre8", {24'd0, rd_data8}, 32'd3);
      check("clr_read_valid", {31'd0, rd_valid16}, 32'd1);
      clr = 1'b0;
      step();
      check("clr_read_post16", {16'd0, rd_data16}, 32'd0);
      check("clr_read_post8", {24'd0, rd_data8}, 32'd0);
      check("b2b_valid", {31'd0, rd_valid16}, 32'd1);
      rd_en = 1'b0;
      step();
      rd("zero_after_clr", 3'd0, 16'd0, 8'd0);

      // unused addresses
      rd("addr6", 3'd6, 16'd0, 8'd0);
      rd("addr7", 3'd7, 16'd0, 8'd0);
`ifdef FLAG_MONITOR_CYCLE_CNT_EN
      zero = 1'b0; carry = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      step(36);
      stack_overflow = 1'b1; step();
      stack_overflow = 1'b0; step();
      rd("ts37", 3'd5, 16'd37, 8'd37);
      rd("cyc_frozen_a", 3'd4, 16'd38, 8'd38);
      rd("cyc_frozen_b", 3'd4, 16'd38, 8'd38);
`else
      rd("addr4", 3'd4, 16'd0, 8'd0);
      rd("addr5", 3'd5, 16'd0, 8'd0);
`endif

      // rst beats clr and rd_en
      zero = 1'b0; carry = 1'b0;
      stack_overflow = 1'b1; step();
      stack_overflow = 1'b0; step();
      check_out("pre_rst_halt", 1'b1, 1'b1);
      rst = 1'b1; clr = 1'b1; rd_en = 1'b1; rd_addr = 3'd3;
      step();
      check("rst_prio.valid", {31'd0, rd_valid16}, 32'd0);
      check("rst_prio.data", {16'd0, rd_data16}, 32'd0);
      check_out("rst_prio", 1'b0, 1'b0);
      rst = 1'b0; clr = 1'b0; rd_en = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
